// File: rtl/irrigation_zone_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irrigation_zone_scheduler_if: sensor inputs and zone/tank outputs    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface irrigation_zone_scheduler_if #(
  parameter int ZONES       = 4,
  parameter int TIMER_WIDTH = 8
);
  localparam int AW = (ZONES > 1) ? $clog2(ZONES) : 1;

  logic                   tick;
  logic                   low_water_level;
  logic                   mid_water_level;
  logic                   high_water_level;
  logic [ZONES-1:0]       zone_dry;
  logic                   air_humidity;
  logic                   low_temperature;
  logic [ZONES-1:0]       sprinkler_bomb;
  logic [ZONES-1:0]       dripper_valvule;
  logic [AW-1:0]          active_zone;
  logic                   busy;
  logic [TIMER_WIDTH-1:0] remaining;
  logic                   water_supply_valvule;
  logic                   conflicting_values;
  logic                   alarm;

  modport master (
    output tick, low_water_level, mid_water_level, high_water_level,
           zone_dry, air_humidity, low_temperature,
    input  sprinkler_bomb, dripper_valvule, active_zone, busy, remaining,
           water_supply_valvule, conflicting_values, alarm
  );

  modport slave (
    input  tick, low_water_level, mid_water_level, high_water_level,
           zone_dry, air_humidity, low_temperature,
    output sprinkler_bomb, dripper_valvule, active_zone, busy, remaining,
           water_supply_valvule, conflicting_values, alarm
  );
endinterface
`default_nettype wire

// File: rtl/irrigation_zone_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irrigation_zone_scheduler: round-robin timed zone irrigation with    |
// | tank level checking and hysteretic refill valve.  Revision: 1.0      |
// +----------------------------------------------------------------------+
module irrigation_zone_scheduler #(
  parameter int ZONES           = 4,
  parameter int TIMER_WIDTH     = 8,
  parameter int SPRINKLER_TICKS = 30,
  parameter int DRIPPER_TICKS   = 60
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  irrigation_zone_scheduler_if.slave bus
);

  localparam int c_aw = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam logic [TIMER_WIDTH-1:0] c_spr_ticks = TIMER_WIDTH'(SPRINKLER_TICKS);
  localparam logic [TIMER_WIDTH-1:0] c_drp_ticks = TIMER_WIDTH'(DRIPPER_TICKS);
  localparam logic [c_aw-1:0]        c_last_zone = c_aw'(ZONES - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IRRIGATE = 1'b1
  } state_t;

  // registered sensor inputs
  logic             r_tick;
  logic             r_low;
  logic             r_mid;
  logic             r_high;
  logic [ZONES-1:0] r_dry;
  logic             r_humid;
  logic             r_cold;

  // state and registered outputs
  state_t                 r_state;
  logic [c_aw-1:0]        r_ptr;
  logic [c_aw-1:0]        r_active;
  logic [TIMER_WIDTH-1:0] r_rem;
  logic [ZONES-1:0]       r_spr;
  logic [ZONES-1:0]       r_drip;
  logic                   r_busy;
  logic                   r_valve;
  logic                   r_conflict;
  logic                   r_alarm;

  state_t                 w_state_nxt;
  logic [c_aw-1:0]        w_ptr_nxt;
  logic [c_aw-1:0]        w_active_nxt;
  logic [TIMER_WIDTH-1:0] w_rem_nxt;
  logic [ZONES-1:0]       w_spr_nxt;
  logic [ZONES-1:0]       w_drip_nxt;
  logic                   w_busy_nxt;
  logic                   w_valve_nxt;
  logic                   w_conflict;
  logic                   w_permit;
  logic                   w_spr_mode;
  logic                   w_found;
  logic [c_aw-1:0]        w_pick;
  logic [ZONES-1:0]       w_pick_onehot;
  logic                   w_end_run;
  int                     w_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick  <= 1'b0;
      r_low   <= 1'b0;
      r_mid   <= 1'b0;
      r_high  <= 1'b0;
      r_dry   <= '0;
      r_humid <= 1'b0;
      r_cold  <= 1'b0;
    end else begin
      r_tick  <= bus.tick;
      r_low   <= bus.low_water_level;
      r_mid   <= bus.mid_water_level;
      r_high  <= bus.high_water_level;
      r_dry   <= bus.zone_dry;
      r_humid <= bus.air_humidity;
      r_cold  <= bus.low_temperature;
    end
  end

  assign w_conflict = (r_high & ~r_mid) | (r_mid & ~r_low) | (r_high & ~r_low);
  // permit reacts to the low probe directly so a dropping tank stops a run
  // one cycle before the registered conflict flag would
  assign w_permit   = ~r_conflict & r_low;
  assign w_spr_mode = ~r_humid & ~r_cold & r_mid;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < ZONES; i++) begin
      w_idx = (int'(r_ptr) + i) % ZONES;
      if (!w_found && r_dry[w_idx[c_aw-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[c_aw-1:0];
      end
    end
  end

  assign w_pick_onehot = ZONES'(1) << w_pick;

  always_comb begin
    w_valve_nxt = r_valve;
    if (r_high || r_conflict) begin
      w_valve_nxt = 1'b0;
    end else if (!r_mid) begin
      w_valve_nxt = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_active_nxt = r_active;
    w_rem_nxt    = r_rem;
    w_spr_nxt    = r_spr;
    w_drip_nxt   = r_drip;
    w_busy_nxt   = r_busy;
    w_end_run    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_permit && w_found) begin
          w_state_nxt  = ST_IRRIGATE;
          w_active_nxt = w_pick;
          w_busy_nxt   = 1'b1;
          if (w_spr_mode) begin
            w_rem_nxt  = c_spr_ticks;
            w_spr_nxt  = w_pick_onehot;
            w_drip_nxt = '0;
          end else begin
            w_rem_nxt  = c_drp_ticks;
            w_spr_nxt  = '0;
            w_drip_nxt = w_pick_onehot;
          end
        end
      end

      ST_IRRIGATE: begin
        // early stop outranks a tick landing in the same cycle
        if (!r_dry[r_active] || !w_permit) begin
          w_end_run = 1'b1;
        end else if (r_tick) begin
          if (r_rem == TIMER_WIDTH'(1)) begin
            w_end_run = 1'b1;
          end else begin
            w_rem_nxt = r_rem - TIMER_WIDTH'(1);
          end
        end

        if (w_end_run) begin
          w_state_nxt = ST_IDLE;
          w_rem_nxt   = '0;
          w_spr_nxt   = '0;
          w_drip_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = (r_active == c_last_zone) ? '0 : r_active + c_aw'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_active   <= '0;
      r_rem      <= '0;
      r_spr      <= '0;
      r_drip     <= '0;
      r_busy     <= 1'b0;
      r_valve    <= 1'b0;
      r_conflict <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_active   <= w_active_nxt;
      r_rem      <= w_rem_nxt;
      r_spr      <= w_spr_nxt;
      r_drip     <= w_drip_nxt;
      r_busy     <= w_busy_nxt;
      r_valve    <= w_valve_nxt;
      r_conflict <= w_conflict;
      r_alarm    <= w_conflict | ~r_mid;
    end
  end

  assign bus.sprinkler_bomb       = r_spr;
  assign bus.dripper_valvule      = r_drip;
  assign bus.active_zone          = r_active;
  assign bus.busy                 = r_busy;
  assign bus.remaining            = r_rem;
  assign bus.water_supply_valvule = r_valve;
  assign bus.conflicting_values   = r_conflict;
  assign bus.alarm                = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_zone_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irrigation_zone_scheduler: directed stimulus, queued expectations |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_irrigation_zone_scheduler;

  localparam int ZONES = 4;
  localparam int TW    = 8;
  localparam int SPR   = 3;
  localparam int DRP   = 5;

  typedef struct {
    int zone;
    bit spr;
    int ticks;
    bit full;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   tcnt   = 0;
  exp_t sb_q[$];

  irrigation_zone_scheduler_if #(.ZONES(ZONES), .TIMER_WIDTH(TW)) bus ();

  irrigation_zone_scheduler #(
    .ZONES(ZONES), .TIMER_WIDTH(TW),
    .SPRINKLER_TICKS(SPR), .DRIPPER_TICKS(DRP)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // one-cycle tick every fourth clock
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      bus.tick = (tcnt % 4 == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_levels(input logic l, input logic m, input logic h);
    bus.low_water_level  = l;
    bus.mid_water_level  = m;
    bus.high_water_level = h;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_runs_started", sb_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_idle", int'(bus.busy), 0);
  endtask

  task automatic wait_rem(input int val, input int budget);
    int n = 0;
    while (int'(bus.remaining) != val && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_remaining", int'(bus.remaining), val);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enables"}, int'(bus.sprinkler_bomb | bus.dripper_valvule), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_remaining"}, int'(bus.remaining), 0);
    chk({tag, "_active"}, int'(bus.active_zone), 0);
    chk({tag, "_valve"}, int'(bus.water_supply_valvule), 0);
    chk({tag, "_conflict"}, int'(bus.conflicting_values), 0);
    chk({tag, "_alarm"}, int'(bus.alarm), 0);
  endtask

  // run monitor: pops an expectation at each run start, checks run body and end
  initial begin
    exp_t             cur;
    bit               run_on = 0;
    bit               prev_busy = 0;
    bit               prev_en_zero = 1;
    int               prev_rem = 0;
    int               decs = 0;
    logic [ZONES-1:0] want_spr;
    logic [ZONES-1:0] want_drp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_on       = 0;
        prev_busy    = 0;
        prev_en_zero = 1;
        continue;
      end
      chk("exclusive_enables",
          int'(((bus.sprinkler_bomb & bus.dripper_valvule) == 0) &&
               $onehot0(bus.sprinkler_bomb) && $onehot0(bus.dripper_valvule)), 1);
      if (bus.busy && !prev_busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_run_zone", int'(bus.active_zone), -1);
        end else begin
          cur      = sb_q.pop_front();
          want_spr = cur.spr ? (ZONES'(1) << cur.zone) : '0;
          want_drp = cur.spr ? '0 : (ZONES'(1) << cur.zone);
          chk("start_gap", int'(prev_en_zero), 1);
          chk("start_zone", int'(bus.active_zone), cur.zone);
          chk("start_sprinkler", int'(bus.sprinkler_bomb), int'(want_spr));
          chk("start_dripper", int'(bus.dripper_valvule), int'(want_drp));
          chk("start_remaining", int'(bus.remaining), cur.ticks);
          run_on   = 1;
          prev_rem = int'(bus.remaining);
          decs     = 0;
        end
      end else if (run_on) begin
        if (int'(bus.remaining) == prev_rem - 1) decs++;
        prev_rem = int'(bus.remaining);
        if (bus.busy) begin
          chk("run_sprinkler_held", int'(bus.sprinkler_bomb), int'(want_spr));
          chk("run_dripper_held", int'(bus.dripper_valvule), int'(want_drp));
        end else begin
          chk("end_remaining", int'(bus.remaining), 0);
          chk("end_enables", int'(bus.sprinkler_bomb | bus.dripper_valvule), 0);
          chk("end_active_zone", int'(bus.active_zone), cur.zone);
          if (cur.full) chk("end_tick_count", decs, cur.ticks);
          run_on = 0;
        end
      end
      prev_busy    = bus.busy;
      prev_en_zero = ((bus.sprinkler_bomb | bus.dripper_valvule) == 0);
    end
  end

  initial begin
    rst_n               = 1'b0;
    set_levels(1'b1, 1'b1, 1'b1);
    bus.zone_dry        = '0;
    bus.air_humidity    = 1'b0;
    bus.low_temperature = 1'b0;
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(3);
    chk("full_tank_valve", int'(bus.water_supply_valvule), 0);
    chk("full_tank_alarm", int'(bus.alarm), 0);
    chk("full_tank_conflict", int'(bus.conflicting_values), 0);

    // zone 2 alone: a full sprinkler run, then a restart cut short
    sb_q.push_back('{2, 1'b1, SPR, 1'b1});
    sb_q.push_back('{2, 1'b1, SPR, 1'b0});
    bus.zone_dry = 4'b0100;
    wait_empty(200);
    wait_rem(2, 40);
    bus.air_humidity = 1'b1;
    step(2);
    chk("mode_latched", int'(bus.sprinkler_bomb), 4'b0100);
    bus.zone_dry = 4'b0000;
    step(1);
    chk("dry_drop_busy_1", int'(bus.busy), 1);
    step(1);
    chk("dry_drop_busy_2", int'(bus.busy), 0);
    chk("dry_drop_remaining", int'(bus.remaining), 0);
    chk("dry_drop_enables", int'(bus.sprinkler_bomb), 0);

    // refill hysteresis
    set_levels(1'b1, 1'b1, 1'b1); step(3);
    chk("valve_111", int'(bus.water_supply_valvule), 0);
    set_levels(1'b1, 1'b1, 1'b0); step(3);
    chk("valve_110", int'(bus.water_supply_valvule), 0);
    set_levels(1'b1, 1'b0, 1'b0); step(3);
    chk("valve_100", int'(bus.water_supply_valvule), 1);
    chk("alarm_100", int'(bus.alarm), 1);
    set_levels(1'b1, 1'b1, 1'b0); step(3);
    chk("valve_110_hold", int'(bus.water_supply_valvule), 1);
    chk("alarm_110", int'(bus.alarm), 0);
    set_levels(1'b1, 1'b1, 1'b1); step(3);
    chk("valve_111_close", int'(bus.water_supply_valvule), 0);

    // async reset in the middle of a run (pointer is 3 after the zone-2 stop)
    sb_q.push_back('{3, 1'b0, DRP, 1'b0});
    bus.zone_dry = 4'b1111;
    wait_empty(50);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step(2);
    for (int z = 0; z < 5; z++) sb_q.push_back('{z % ZONES, 1'b0, DRP, 1'b1});
    rst_n = 1'b1;
    wait_empty(600);

    // level conflict during a zone-2 run
    sb_q.push_back('{1, 1'b0, DRP, 1'b1});
    sb_q.push_back('{2, 1'b0, DRP, 1'b0});
    wait_empty(300);
    step(1);
    set_levels(1'b0, 1'b1, 1'b0);
    step(1);
    chk("conflict_busy_1", int'(bus.busy), 1);
    step(1);
    chk("conflict_busy_2", int'(bus.busy), 0);
    chk("conflict_enables", int'(bus.dripper_valvule | bus.sprinkler_bomb), 0);
    chk("conflict_flag", int'(bus.conflicting_values), 1);
    chk("conflict_alarm", int'(bus.alarm), 1);

    sb_q.push_back('{3, 1'b0, DRP, 1'b0});
    set_levels(1'b1, 1'b1, 1'b1);
    wait_empty(100);
    step(3);
    bus.zone_dry = 4'b0000;
    wait_idle(20);
    step(3);
    chk("queue_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
